// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the DLX pipeline sequencer: FSM states, control bundle and output resolution.
package dlx_pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    ERR      = 2'd3
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_hold;
    logic ifid_hold;
    logic ifid_flush;
    logic idex_bubble;
    logic back_hold;
    logic mem_err;
  } pipe_ctrl_t;

  // A flush always beats a hold on IF/ID, and a frozen back end freezes ID->EX too.
  function automatic pipe_ctrl_t resolve_ctrl(input pipe_ctrl_t c);
    pipe_ctrl_t r;
    r = c;
    if (r.ifid_flush) r.ifid_hold = 1'b0;
    if (r.back_hold) r.idex_bubble = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the hazard sequencer: stage fields in, hold/flush/bubble controls out.
interface hazard_ctrl_if;

  logic [4:0] Rs1_ID;
  logic [4:0] Rs2_ID;
  logic       use_rs2_ID;
  logic [4:0] Rd_EX;
  logic       d_load_enable_EX;
  logic       pc_cmd_EX;
  logic       Pc_cmd_id;
  logic       d_req_MEM;
  logic       d_ack_MEM;

  logic       pc_hold;
  logic       ifid_hold;
  logic       ifid_flush;
  logic       idex_bubble;
  logic       back_hold;
  logic       mem_err;

  modport master (
    output Rs1_ID, Rs2_ID, use_rs2_ID, Rd_EX, d_load_enable_EX,
           pc_cmd_EX, Pc_cmd_id, d_req_MEM, d_ack_MEM,
    input  pc_hold, ifid_hold, ifid_flush, idex_bubble, back_hold, mem_err
  );

  modport slave (
    input  Rs1_ID, Rs2_ID, use_rs2_ID, Rd_EX, d_load_enable_EX,
           pc_cmd_EX, Pc_cmd_id, d_req_MEM, d_ack_MEM,
    output pc_hold, ifid_hold, ifid_flush, idex_bubble, back_hold, mem_err
  );

endinterface

// File: rtl/hazard_ctrl_detect.sv
// Combinational read-after-write compare between a producing stage and the ID source operands.
module hazard_detect
  import dlx_pipe_pkg::*;
(
  input  logic [4:0] rd,
  input  logic       rd_valid,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       use_rs2,
  output logic       hazard
);

  logic hit_rs1;
  logic hit_rs2;

  always_comb begin
    hit_rs1 = (rd == rs1);
    hit_rs2 = use_rs2 && (rd == rs2);
    hazard  = rd_valid && (rd != REG_ZERO) && (hit_rs1 || hit_rs2);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// DLX hazard sequencer: owns PC/IF-ID/ID-EX/back-end hold, flush and bubble decisions.
// Optional performance counters (stall_cnt, flush_cnt, cnt_clr) under `HAZARD_PERF_CNT_EN.
module hazard_ctrl
  import dlx_pipe_pkg::*;
#(
  parameter int unsigned LOAD_USE_CYC = 1,
  parameter int unsigned MEM_TMO      = 15
) (
  input  logic          clk,
  input  logic          reset_n,
  hazard_ctrl_if.slave  hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  input  logic          cnt_clr,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   flush_cnt
`endif
);

  localparam logic [1:0] LD_EXTRA = 2'(LOAD_USE_CYC - 1);
  localparam logic [3:0] TMO      = 4'(MEM_TMO);

  hz_state_t  state, state_nx;
  logic [1:0] ld_cnt, ld_cnt_nx;
  logic [3:0] mem_cnt, mem_cnt_nx;
  logic       load_use;
  logic       mem_wait;
  logic       ld_pending;
  pipe_ctrl_t ctrl_raw;
  pipe_ctrl_t ctrl;

  hazard_detect u_detect (
    .rd       (hz.Rd_EX),
    .rd_valid (hz.d_load_enable_EX),
    .rs1      (hz.Rs1_ID),
    .rs2      (hz.Rs2_ID),
    .use_rs2  (hz.use_rs2_ID),
    .hazard   (load_use)
  );

  assign mem_wait = hz.d_req_MEM & ~hz.d_ack_MEM;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= RUN;
      ld_cnt  <= '0;
      mem_cnt <= '0;
    end else begin
      state   <= state_nx;
      ld_cnt  <= ld_cnt_nx;
      mem_cnt <= mem_cnt_nx;
    end
  end

  // ld_cnt survives a MEM wait, so a nonzero count in MEM_WAIT means the ack
  // cycle resumes the interrupted load-use stall rather than returning to RUN.
  always_comb begin
    state_nx   = state;
    ld_cnt_nx  = ld_cnt;
    mem_cnt_nx = '0;
    ctrl_raw   = '0;
    ld_pending = (state == LD_STALL) || ((state == MEM_WAIT) && (ld_cnt != '0));

    if (state == ERR) begin
      ctrl_raw.pc_hold   = 1'b1;
      ctrl_raw.ifid_hold = 1'b1;
      ctrl_raw.back_hold = 1'b1;
      ctrl_raw.mem_err   = 1'b1;
    end else if (mem_wait) begin
      ctrl_raw.pc_hold   = 1'b1;
      ctrl_raw.ifid_hold = 1'b1;
      ctrl_raw.back_hold = 1'b1;
      mem_cnt_nx         = mem_cnt + 4'd1;
      state_nx           = (mem_cnt_nx == TMO) ? ERR : MEM_WAIT;
    end else if (hz.pc_cmd_EX) begin
      ctrl_raw.ifid_flush  = 1'b1;
      ctrl_raw.idex_bubble = 1'b1;
      ld_cnt_nx            = '0;
      state_nx             = RUN;
    end else if (ld_pending) begin
      ctrl_raw.pc_hold     = 1'b1;
      ctrl_raw.ifid_hold   = 1'b1;
      ctrl_raw.idex_bubble = 1'b1;
      ld_cnt_nx            = ld_cnt - 2'd1;
      state_nx             = (ld_cnt == 2'd1) ? RUN : LD_STALL;
    end else if (load_use) begin
      ctrl_raw.pc_hold     = 1'b1;
      ctrl_raw.ifid_hold   = 1'b1;
      ctrl_raw.idex_bubble = 1'b1;
      if (LOAD_USE_CYC > 1) begin
        ld_cnt_nx = LD_EXTRA;
        state_nx  = LD_STALL;
      end else begin
        state_nx  = RUN;
      end
    end else begin
      ctrl_raw.ifid_flush = hz.Pc_cmd_id;
      state_nx            = RUN;
    end
  end

  always_comb begin
    ctrl = resolve_ctrl(ctrl_raw);
    if (!reset_n) ctrl = '0;
  end

  assign hz.pc_hold     = ctrl.pc_hold;
  assign hz.ifid_hold   = ctrl.ifid_hold;
  assign hz.ifid_flush  = ctrl.ifid_flush;
  assign hz.idex_bubble = ctrl.idex_bubble;
  assign hz.back_hold   = ctrl.back_hold;
  assign hz.mem_err     = ctrl.mem_err;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 32'(ctrl.pc_hold);
      flush_cnt <= flush_cnt + 32'(ctrl.ifid_flush);
    end
  end
`endif

endmodule
